// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, control-word layout and decode payload for the pipelined MIPS control unit.
package pipe_ctrl_pkg;

    localparam int unsigned OP_W = 6;
    localparam int unsigned CW_W = 10;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

    localparam int unsigned CW_MEMTOREG  = 9;
    localparam int unsigned CW_REGWRITE  = 8;
    localparam int unsigned CW_BRANCH    = 7;
    localparam int unsigned CW_BNE       = 6;
    localparam int unsigned CW_MEMREAD   = 5;
    localparam int unsigned CW_MEMWRITE  = 4;
    localparam int unsigned CW_REGDST    = 3;
    localparam int unsigned CW_ALUSRC    = 2;
    localparam int unsigned CW_ALUOP_MSB = 1;
    localparam int unsigned CW_ALUOP_LSB = 0;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    typedef logic [CW_W-1:0] cw_t;

    typedef struct packed {
        cw_t  cw;
        logic jump;
        logic uses_rt;
        logic illegal;
    } dec_t;

    function automatic cw_t cw_pack(
        input logic       memtoreg,
        input logic       regwrite,
        input logic       branch,
        input logic       bne,
        input logic       memread,
        input logic       memwrite,
        input logic       regdst,
        input logic       alusrc,
        input logic [1:0] aluop
    );
        cw_t cw;
        cw                            = '0;
        cw[CW_MEMTOREG]               = memtoreg;
        cw[CW_REGWRITE]               = regwrite;
        cw[CW_BRANCH]                 = branch;
        cw[CW_BNE]                    = bne;
        cw[CW_MEMREAD]                = memread;
        cw[CW_MEMWRITE]               = memwrite;
        cw[CW_REGDST]                 = regdst;
        cw[CW_ALUSRC]                 = alusrc;
        cw[CW_ALUOP_MSB:CW_ALUOP_LSB] = aluop;
        return cw;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID-stage inputs and pipeline control/tap outputs of the control unit.
interface pipe_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) ();
    import pipe_ctrl_pkg::*;

    logic              valid_id;
    logic [OP_W-1:0]   op_id;
    logic [REG_AW-1:0] rs_id;
    logic [REG_AW-1:0] rt_id;
    logic [REG_AW-1:0] rd_id;
    logic              br_taken_ex;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              jump_id;
    logic              illegal_id;
    logic [CW_W-1:0]   cw_ex;
    logic [CW_W-1:0]   cw_mem;
    logic [CW_W-1:0]   cw_wb;
    logic [REG_AW-1:0] dst_ex;
    logic [REG_AW-1:0] dst_mem;
    logic [REG_AW-1:0] dst_wb;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output valid_id, op_id, rs_id, rt_id, rd_id, br_taken_ex,
        input  pc_write, ifid_write, ifid_flush, jump_id, illegal_id,
        input  cw_ex, cw_mem, cw_wb, dst_ex, dst_mem, dst_wb,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  valid_id, op_id, rs_id, rt_id, rd_id, br_taken_ex,
        output pc_write, ifid_write, ifid_flush, jump_id, illegal_id,
        output cw_ex, cw_mem, cw_wb, dst_ex, dst_mem, dst_wb,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control word, jump, rt-as-source and illegal flags.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic            i_valid,
    input  logic [OP_W-1:0] i_op,
    output dec_t            o_dec
);

    always_comb begin
        o_dec         = '0;
        // rt is read as a source whenever the opcode compares or stores it
        o_dec.uses_rt = (i_op == OP_RTYPE) || (i_op == OP_SW) ||
                        (i_op == OP_BEQ)   || (i_op == OP_BNE);
        if (i_valid) begin
            case (i_op)
                OP_RTYPE: o_dec.cw = cw_pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_FUNCT);
                OP_LW:    o_dec.cw = cw_pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, ALUOP_ADD);
                OP_SW:    o_dec.cw = cw_pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ALUOP_ADD);
                OP_BEQ:   o_dec.cw = cw_pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_SUB);
                OP_BNE:   o_dec.cw = cw_pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_SUB);
                OP_ADDI:  o_dec.cw = cw_pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_ADD);
                OP_ANDI,
                OP_ORI:   o_dec.cw = cw_pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_LOGIC);
                OP_J:     o_dec.jump = 1'b1;
                default:  o_dec.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode, load-use stall, branch/jump flush, ID/EX..MEM/WB control regs, perf counters.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW    = 5,
    parameter bit          HAZARD_EN = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_ctrl_if.slave bus
);

    dec_t              w_dec;
    logic [REG_AW-1:0] w_dst_id;
    logic              w_hazard;
    logic              w_stall;
    logic              w_flush;
    logic              w_bubble;

    cw_t               r_cw_ex;
    cw_t               r_cw_mem;
    cw_t               r_cw_wb;
    logic [REG_AW-1:0] r_dst_ex;
    logic [REG_AW-1:0] r_dst_mem;
    logic [REG_AW-1:0] r_dst_wb;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    ctrl_decode u_decode (
        .i_valid (bus.valid_id),
        .i_op    (bus.op_id),
        .o_dec   (w_dec)
    );

    // Hazard, flush and bubble selection; a taken branch overrides the stall
    always_comb begin
        w_dst_id = w_dec.cw[CW_REGDST] ? bus.rd_id : bus.rt_id;
        w_hazard = HAZARD_EN && r_cw_ex[CW_MEMREAD] && (r_dst_ex != '0) &&
                   ((r_dst_ex == bus.rs_id) || (w_dec.uses_rt && (r_dst_ex == bus.rt_id)));
        w_stall  = w_hazard && !bus.br_taken_ex;
        w_flush  = bus.br_taken_ex || (w_dec.jump && !w_hazard);
        w_bubble = w_hazard || bus.br_taken_ex;
    end

    assign bus.pc_write   = !w_stall;
    assign bus.ifid_write = !w_stall;
    assign bus.ifid_flush = w_flush;
    assign bus.jump_id    = w_dec.jump;
    assign bus.illegal_id = w_dec.illegal;
    assign bus.cw_ex      = r_cw_ex;
    assign bus.cw_mem     = r_cw_mem;
    assign bus.cw_wb      = r_cw_wb;
    assign bus.dst_ex     = r_dst_ex;
    assign bus.dst_mem    = r_dst_mem;
    assign bus.dst_wb     = r_dst_wb;
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;

    // Stage registers; the destination is cleared whenever the control word is a bubble
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cw_ex   <= '0;
            r_cw_mem  <= '0;
            r_cw_wb   <= '0;
            r_dst_ex  <= '0;
            r_dst_mem <= '0;
            r_dst_wb  <= '0;
        end else begin
            if (w_bubble || (w_dec.cw == '0)) begin
                r_cw_ex  <= '0;
                r_dst_ex <= '0;
            end else begin
                r_cw_ex  <= w_dec.cw;
                r_dst_ex <= w_dst_id;
            end
            r_cw_mem  <= r_cw_ex;
            r_dst_mem <= r_dst_ex;
            r_cw_wb   <= r_cw_mem;
            r_dst_wb  <= r_dst_mem;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit with a scoreboard of expected ID/EX contents and a spec-level pipe model.
module tb_pipe_ctrl_unit;

    localparam int unsigned TB_AW  = 5;
    localparam int unsigned TB_CNT = 4;
    localparam int          CNT_MAX = (1 << TB_CNT) - 1;

    localparam logic [5:0] T_R = 6'h00, T_LW = 6'h23, T_SW = 6'h2B, T_BEQ = 6'h04, T_BNE = 6'h05;
    localparam logic [5:0] T_J = 6'h02, T_ADDI = 6'h08, T_ANDI = 6'h0C, T_ORI = 6'h0D, T_BAD = 6'h3F;

    typedef struct {
        logic [9:0] cw;
        logic [4:0] dst;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    exp_t sbq[$];
    logic [9:0] m_ex_cw, m_mem_cw, m_wb_cw;
    logic [4:0] m_ex_dst, m_mem_dst, m_wb_dst;
    int         m_stall, m_flush;

    pipe_ctrl_if #(.REG_AW(TB_AW), .CNT_W(TB_CNT)) bus ();

    pipe_ctrl_unit #(.REG_AW(TB_AW), .HAZARD_EN(1'b1), .CNT_W(TB_CNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] ref_cw(input logic v, input logic [5:0] op);
        if (!v) return 10'h000;
        case (op)
            T_R:           return 10'h10A;
            T_LW:          return 10'h324;
            T_SW:          return 10'h014;
            T_BEQ:         return 10'h081;
            T_BNE:         return 10'h0C1;
            T_ADDI:        return 10'h104;
            T_ANDI, T_ORI: return 10'h107;
            default:       return 10'h000;
        endcase
    endfunction

    function automatic logic ref_legal(input logic [5:0] op);
        return (op == T_R) || (op == T_LW) || (op == T_SW) || (op == T_BEQ) || (op == T_BNE) ||
               (op == T_J) || (op == T_ADDI) || (op == T_ANDI) || (op == T_ORI);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic br, input logic rstv);
        logic [9:0] e_cw, n_cw;
        logic [4:0] n_dst;
        logic       ur, hz, jmp, stl, fl;
        exp_t       e;
        @(negedge clk);
        bus.valid_id    = v;
        bus.op_id       = op;
        bus.rs_id       = rs;
        bus.rt_id       = rt;
        bus.rd_id       = rd;
        bus.br_taken_ex = br;
        rst_n           = rstv;
        #1;
        e_cw = ref_cw(v, op);
        ur   = (op == T_R) || (op == T_SW) || (op == T_BEQ) || (op == T_BNE);
        hz   = m_ex_cw[5] && (m_ex_dst != 5'd0) && ((m_ex_dst == rs) || (ur && (m_ex_dst == rt)));
        jmp  = v && (op == T_J);
        stl  = hz && !br;
        fl   = br || (jmp && !hz);
        chk({tag, ".pc_write"},   32'(bus.pc_write),   32'(!stl));
        chk({tag, ".ifid_write"}, 32'(bus.ifid_write), 32'(!stl));
        chk({tag, ".ifid_flush"}, 32'(bus.ifid_flush), 32'(fl));
        chk({tag, ".jump_id"},    32'(bus.jump_id),    32'(jmp));
        chk({tag, ".illegal_id"}, 32'(bus.illegal_id), 32'(v && !ref_legal(op)));
        n_cw  = (!rstv || hz || br) ? 10'h000 : e_cw;
        n_dst = (n_cw == 10'h000) ? 5'd0 : (e_cw[3] ? rd : rt);
        sbq.push_back('{cw: n_cw, dst: n_dst});
        @(posedge clk);
        #1;
        if (!rstv) begin
            m_stall = 0;
            m_flush = 0;
            m_mem_cw = '0; m_mem_dst = '0; m_wb_cw = '0; m_wb_dst = '0;
        end else begin
            if (stl && m_stall < CNT_MAX) m_stall++;
            if (fl && m_flush < CNT_MAX) m_flush++;
            m_wb_cw = m_mem_cw; m_wb_dst = m_mem_dst;
            m_mem_cw = m_ex_cw; m_mem_dst = m_ex_dst;
        end
        if (sbq.size() == 0) begin
            chk({tag, ".sbq_empty"}, 32'(1), 32'(0));
        end else begin
            e = sbq.pop_front();
            m_ex_cw  = e.cw;
            m_ex_dst = e.dst;
            chk({tag, ".cw_ex"},  32'(bus.cw_ex),  32'(e.cw));
            chk({tag, ".dst_ex"}, 32'(bus.dst_ex), 32'(e.dst));
        end
        chk({tag, ".cw_mem"},    32'(bus.cw_mem),    32'(m_mem_cw));
        chk({tag, ".cw_wb"},     32'(bus.cw_wb),     32'(m_wb_cw));
        chk({tag, ".dst_wb"},    32'(bus.dst_wb),    32'(m_wb_dst));
        chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(m_stall));
        chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(m_flush));
    endtask

    task automatic bub(input string tag);
        step(tag, 1'b0, T_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.valid_id = 1'b0; bus.op_id = '0; bus.rs_id = '0; bus.rt_id = '0; bus.rd_id = '0;
        bus.br_taken_ex = 1'b0;
        m_ex_cw = '0; m_mem_cw = '0; m_wb_cw = '0;
        m_ex_dst = '0; m_mem_dst = '0; m_wb_dst = '0;
        m_stall = 0; m_flush = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.cw_ex",     32'(bus.cw_ex),     32'(0));
        chk("rst.cw_mem",    32'(bus.cw_mem),    32'(0));
        chk("rst.cw_wb",     32'(bus.cw_wb),     32'(0));
        chk("rst.dst_ex",    32'(bus.dst_ex),    32'(0));
        chk("rst.stall_cnt", 32'(bus.stall_cnt), 32'(0));
        chk("rst.flush_cnt", 32'(bus.flush_cnt), 32'(0));

        // Decode table walk through all stages
        step("t1.add",  1'b1, T_R,    5'd1, 5'd2,  5'd3, 1'b0, 1'b1);
        step("t1.lw",   1'b1, T_LW,   5'd4, 5'd5,  5'd0, 1'b0, 1'b1);
        step("t1.sw",   1'b1, T_SW,   5'd6, 5'd7,  5'd0, 1'b0, 1'b1);
        step("t1.beq",  1'b1, T_BEQ,  5'd8, 5'd9,  5'd0, 1'b0, 1'b1);
        step("t1.bne",  1'b1, T_BNE,  5'd8, 5'd9,  5'd0, 1'b0, 1'b1);
        step("t1.addi", 1'b1, T_ADDI, 5'd1, 5'd10, 5'd0, 1'b0, 1'b1);
        step("t1.andi", 1'b1, T_ANDI, 5'd1, 5'd11, 5'd0, 1'b0, 1'b1);
        step("t1.ori",  1'b1, T_ORI,  5'd1, 5'd12, 5'd0, 1'b0, 1'b1);
        step("t1.j",    1'b1, T_J,    5'd0, 5'd0,  5'd0, 1'b0, 1'b1);
        repeat (3) bub("t1.drain");

        // Load-use stall, add held one cycle in ID
        step("t2.lw",   1'b1, T_LW, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1);
        step("t2.stl",  1'b1, T_R,  5'd2, 5'd4, 5'd3, 1'b0, 1'b1);
        step("t2.add",  1'b1, T_R,  5'd2, 5'd4, 5'd3, 1'b0, 1'b1);
        chk("t2.stall_cnt_is_1", 32'(bus.stall_cnt), 32'(1));

        // No-hazard cases
        step("t3.lw",   1'b1, T_LW,   5'd0, 5'd2, 5'd0, 1'b0, 1'b1);
        step("t3.addi", 1'b1, T_ADDI, 5'd0, 5'd2, 5'd5, 1'b0, 1'b1);
        step("t3.lw0",  1'b1, T_LW,   5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        step("t3.add0", 1'b1, T_R,    5'd0, 5'd4, 5'd3, 1'b0, 1'b1);

        // Stall coincident with taken branch
        step("t4.lw",   1'b1, T_LW, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1);
        step("t4.brst", 1'b1, T_R,  5'd2, 5'd4, 5'd3, 1'b1, 1'b1);
        bub("t4.after");

        // Jump flush, flushed add never reaches EX, illegal opcode
        step("t5.j",    1'b1, T_J,   5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        step("t5.add",  1'b0, T_R,   5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        step("t5.bad",  1'b1, T_BAD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        step("t5.lwj",  1'b1, T_LW,  5'd0, 5'd6, 5'd0, 1'b0, 1'b1);
        step("t5.jst",  1'b1, T_J,   5'd6, 5'd0, 5'd0, 1'b0, 1'b1);
        step("t5.jre",  1'b1, T_J,   5'd6, 5'd0, 5'd0, 1'b0, 1'b1);

        // Mid-operation reset, then stall counter saturation
        step("t6.lw",   1'b1, T_LW, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1);
        step("t6.add",  1'b1, T_R,  5'd2, 5'd4, 5'd3, 1'b0, 1'b1);
        step("t6.rst",  1'b1, T_R,  5'd2, 5'd4, 5'd3, 1'b0, 1'b0);
        for (int i = 0; i < 42; i++) begin
            step("t6.sat", 1'b1, T_LW, 5'd2, 5'd2, 5'd0, 1'b0, 1'b1);
        end
        chk("t6.stall_saturated", 32'(bus.stall_cnt), 32'(CNT_MAX));
        repeat (3) bub("t6.drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
